tmod_master: RTL and testbench
==============================

TMOD_MASTER -- requirements
Module: tmod_master

Interface
REQ-001 Parameter TIMEOUT, 16, the maximum number of WAIT cycles before a command is aborted; legal range 2..255.
REQ-002 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port cmd_valid, input, 1 bit: the host presents a command.
REQ-005 Port cmd_op, input, 4 bits: the opcode. 0000 RESET, 0001 SET_FRQ, 0010 SET_HIGH_TEMP, 0011 SET_LOW_TEMP, 0100 OUT_MAX, 0101 OUT_MIN, 0110 OUT_ADDR, 0111 OUT_AVG, 1xxx NOOP.
REQ-006 Port cmd_opnd, input, 8 bits: the command operand.
REQ-007 Port cmd_ready, output, 1 bit: the master can accept a command.
REQ-008 Port result_valid, output, 1 bit: a one-cycle completion pulse.
REQ-009 Port result_data, output, 8 bits: the read data; 0 for write, NOOP and aborted commands.
REQ-010 Port result_err, output, 1 bit: the command timed out.
REQ-011 Port result_status, output, 2 bits: bus_status sampled at completion.
REQ-012 Port op, output, 4 bits: the bus opcode to the slave.
REQ-013 Port opnd, output, 8 bits: the bus operand to the slave.
REQ-014 Port bus_ready, input, 1 bit: the slave is ready.
REQ-015 Port bus_valid, input, 1 bit: the slave data is valid.
REQ-016 Port bus_data, input, 8 bits: the slave data output.
REQ-017 Port bus_status, input, 2 bits: the slave status. 00 OK, 01 HIGH, 10 LOW, 11 treated as OK.
REQ-018 Port alarm_clr, input, 1 bit: the host clears the sticky alarms.
REQ-019 Port alarm_high, output, 1 bit: sticky flag, HIGH seen.
REQ-020 Port alarm_low, output, 1 bit: sticky flag, LOW seen.

Function
REQ-021 The FSM SHALL have exactly the states IDLE, ISSUE, WAIT and DONE.
REQ-022 In IDLE: op=4'b1000 (NOOP) and cmd_ready=bus_ready; a handshake (cmd_valid && cmd_ready) SHALL latch cmd_op/cmd_opnd and move to ISSUE.
REQ-023 cmd_valid while cmd_ready=0 SHALL be ignored, with no latching.
REQ-024 In ISSUE: op/opnd SHALL drive the latched values for exactly one cycle, clear the wait counter, and move to WAIT.
REQ-025 In WAIT: op SHALL return to NOOP; opnd SHALL hold the latched value; the wait counter SHALL increment by 1 per cycle (8-bit, no wrap).
REQ-026 Write ops (0000..0011) SHALL complete on the first WAIT cycle with bus_ready=1; result_data=0.
REQ-027 Read ops (0100..0111) SHALL complete on the first WAIT cycle with bus_valid=1; that cycle's bus_data SHALL be captured.
REQ-028 NOOP (1xxx) SHALL complete on the first WAIT cycle unconditionally; result_data=0.
REQ-029 If the counter equals TIMEOUT-1 without completion, the command SHALL complete with result_err=1 and result_data=0.
REQ-030 A completion condition in the same cycle as timeout SHALL win, giving result_err=0.
REQ-031 Completion SHALL move the FSM to DONE: result_valid=1 for that one cycle, result_status=bus_status sampled on the completing cycle; then IDLE.
REQ-032 Latency: handshake at cycle N, ISSUE N+1, first WAIT N+2; the earliest result_valid is N+3.
REQ-033 result_data/err/status SHALL hold until the next completion.
REQ-034 The alarm logic SHALL be independent of the FSM: each cycle, bus_status=01 sets alarm_high and bus_status=10 sets alarm_low.
REQ-035 alarm_clr SHALL clear both alarms; a set in the same cycle SHALL win over clear.
REQ-036 Completion of a RESET (0000) command SHALL clear both alarms, with the same priority as alarm_clr.

Reset
REQ-037 While reset=1 the block SHALL be in IDLE with op=4'b1000, opnd=0, cmd_ready=0, result_valid=0, result_data=0, result_err=0, result_status=00, alarm_high=0, alarm_low=0, and counter=0.
REQ-038 Reset mid-command SHALL abandon the command with no result_valid pulse; the first accept is possible on the first edge after deassertion with bus_ready=1.

Verification
REQ-039 SET_HIGH_TEMP opnd=8'h50 with bus_ready=1 -> op=0010/opnd=50 for one cycle; result_valid at N+3 with data=00, err=0.
REQ-040 OUT_MAX with bus_valid raised 3 cycles after ISSUE carrying bus_data=8'h3C -> result_data=3C, err=0, result_valid exactly once.
REQ-041 OUT_AVG with bus_valid held 0 and TIMEOUT=16 -> result_err=1, data=00 after 16 WAIT cycles; the next command is accepted normally.
REQ-042 bus_status=01 for one cycle, then alarm_clr=1 while bus_status=10 -> alarm_high=1 stays until the clear; alarm_low=1 survives the clear (set wins).
REQ-043 cmd_valid=1 while bus_ready=0 -> cmd_ready=0 and no op change; bus_ready rises -> accepted next edge.
REQ-044 reset asserted during WAIT of OUT_MIN -> outputs take reset values immediately; no result_valid; a new NOOP completes in 3 cycles after deassertion.

Source files
------------

// File: rtl/tmod_master.sv
// Command master: takes one host command, issues it on the slave bus, waits for
// completion or timeout, and keeps sticky HIGH/LOW alarms from the slave status.
module tmod_master #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [3:0] cmd_op,
  input  logic [7:0] cmd_opnd,
  output logic       cmd_ready,
  output logic       result_valid,
  output logic [7:0] result_data,
  output logic       result_err,
  output logic [1:0] result_status,
  output logic [3:0] op,
  output logic [7:0] opnd,
  input  logic       bus_ready,
  input  logic       bus_valid,
  input  logic [7:0] bus_data,
  input  logic [1:0] bus_status,
  input  logic       alarm_clr,
  output logic       alarm_high,
  output logic       alarm_low
);
  // state | meaning
  // IDLE  | op=NOOP, accept a command while bus_ready
  // ISSUE | drive latched op/opnd for one cycle, clear wait counter
  // WAIT  | wait for bus_ready (write) / bus_valid (read), or time out
  // DONE  | one-cycle result_valid pulse
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [3:0] OP_NOOP  = 4'b1000;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [3:0] op_q;
  logic [7:0] opnd_q;
  logic [7:0] wait_cnt;
  logic       accept, hit, timed_out, complete;
  logic       is_read, is_write, clr_any;

  assign is_read  = ~op_q[3] &  op_q[2];
  assign is_write = ~op_q[3] & ~op_q[2];

  always_comb begin
    state_nxt = state;
    op        = OP_NOOP;
    cmd_ready = 1'b0;
    accept    = 1'b0;
    hit       = 1'b0;
    timed_out = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = bus_ready & ~reset;
        accept    = cmd_valid & bus_ready & ~reset;
        if (accept) state_nxt = ISSUE;
      end
      ISSUE: begin
        op        = op_q;
        state_nxt = WAIT;
      end
      WAIT: begin
        hit       = op_q[3] | (is_read & bus_valid) | (is_write & bus_ready);
        // a completion on the last allowed cycle beats the timeout
        timed_out = ~hit & (wait_cnt == CNT_LAST);
        if (hit | timed_out) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign complete     = hit | timed_out;
  assign result_valid = (state == DONE);
  assign opnd         = opnd_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      op_q          <= OP_NOOP;
      opnd_q        <= '0;
      wait_cnt      <= '0;
      result_data   <= '0;
      result_err    <= 1'b0;
      result_status <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q   <= cmd_op;
        opnd_q <= cmd_opnd;
      end
      if (state == ISSUE)
        wait_cnt <= '0;
      else if (state == WAIT && wait_cnt != 8'hFF)
        wait_cnt <= wait_cnt + 8'd1;
      if (complete) begin
        result_data   <= (hit & is_read) ? bus_data : 8'h00;
        result_err    <= timed_out;
        result_status <= bus_status;
      end
    end
  end

  // a RESET command clears the alarms at the same priority as alarm_clr
  assign clr_any = alarm_clr | (complete & (op_q == 4'b0000));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alarm_high <= 1'b0;
      alarm_low  <= 1'b0;
    end else begin
      if (bus_status == 2'b01)  alarm_high <= 1'b1;
      else if (clr_any)         alarm_high <= 1'b0;
      if (bus_status == 2'b10)  alarm_low  <= 1'b1;
      else if (clr_any)         alarm_low  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_tmod_master.sv
// Self-checking bench for tmod_master: vector table, hand sequences and random
// commands checked against a transaction-level reference model.
module tb_tmod_master;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic [3:0] cmd_op;
  logic [7:0] cmd_opnd;
  logic       cmd_ready;
  logic       result_valid;
  logic [7:0] result_data;
  logic       result_err;
  logic [1:0] result_status;
  logic [3:0] op;
  logic [7:0] opnd;
  logic       bus_ready;
  logic       bus_valid;
  logic [7:0] bus_data;
  logic [1:0] bus_status;
  logic       alarm_clr;
  logic       alarm_high;
  logic       alarm_low;

  tmod_master #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_opnd(cmd_opnd), .cmd_ready(cmd_ready),
    .result_valid(result_valid), .result_data(result_data), .result_err(result_err),
    .result_status(result_status), .op(op), .opnd(opnd),
    .bus_ready(bus_ready), .bus_valid(bus_valid), .bus_data(bus_data), .bus_status(bus_status),
    .alarm_clr(alarm_clr), .alarm_high(alarm_high), .alarm_low(alarm_low)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  logic       exp_ah = 1'b0, exp_al = 1'b0;
  logic [7:0] h_data = 8'h00;
  logic       h_err = 1'b0;
  logic [1:0] h_status = 2'b00;
  logic [7:0] last_opnd = 8'h00;

  // per-WAIT-cycle bus stimulus
  logic       rdy_a[TO];
  logic       vld_a[TO];
  logic       clr_a[TO];
  logic [7:0] dat_a[TO];
  logic [1:0] st_a[TO];

  typedef struct {
    logic [3:0] cop;
    logic [7:0] copnd;
    int         rdy_at;
    int         vld_at;
    logic [7:0] dat;
    int         lat;
    logic [7:0] x_data;
    logic       x_err;
  } vec_t;
  vec_t tbl[10];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // one clock edge plus the sticky alarm rules
  task automatic clk_edge(input bit rst_cmd_done);
    logic nh, nl;
    if (reset) begin
      nh = 1'b0;
      nl = 1'b0;
    end else begin
      nh = (bus_status == 2'b01) ? 1'b1 : (alarm_clr || rst_cmd_done) ? 1'b0 : exp_ah;
      nl = (bus_status == 2'b10) ? 1'b1 : (alarm_clr || rst_cmd_done) ? 1'b0 : exp_al;
    end
    @(posedge clk);
    #1;
    exp_ah = nh;
    exp_al = nl;
    check("alarm_high", alarm_high, exp_ah);
    check("alarm_low", alarm_low, exp_al);
  endtask

  task automatic reset_vals();
    check("rst_op", op, 8'h08);
    check("rst_opnd", opnd, 8'h00);
    check("rst_cmd_ready", cmd_ready, 8'h00);
    check("rst_result_valid", result_valid, 8'h00);
    check("rst_result_data", result_data, 8'h00);
    check("rst_result_err", result_err, 8'h00);
    check("rst_result_status", result_status, 8'h00);
    check("rst_alarm_high", alarm_high, 8'h00);
    check("rst_alarm_low", alarm_low, 8'h00);
  endtask

  // reference: first WAIT cycle meeting the op's completion rule, else timeout on the last
  task automatic model(input logic [3:0] cop, output int k_done, output logic [7:0] d,
                       output logic err, output logic [1:0] st);
    bit found;
    found  = 1'b0;
    k_done = TO - 1;
    d      = 8'h00;
    err    = 1'b1;
    for (int k = 0; k < TO; k++) begin
      if (!found && (cop[3] || (cop[2] ? vld_a[k] : rdy_a[k]))) begin
        found  = 1'b1;
        k_done = k;
        err    = 1'b0;
        d      = (!cop[3] && cop[2]) ? dat_a[k] : 8'h00;
      end
    end
    st = st_a[k_done];
  endtask

  // entered and left in IDLE, just after a clock edge
  task automatic run_cmd(input logic [3:0] cop, input logic [7:0] copnd, input int xk,
                         input logic [7:0] xdata, input logic xerr, input logic [1:0] xst);
    check("op_idle", op, 8'h08);
    check("held_data", result_data, h_data);
    check("held_err", result_err, h_err);
    check("held_status", result_status, h_status);
    cmd_op = cop; cmd_opnd = copnd; cmd_valid = 1'b1;
    bus_ready = 1'b1; bus_valid = 1'b0; bus_status = 2'b00; alarm_clr = 1'b0;
    #1;
    check("cmd_ready_idle", cmd_ready, 8'h01);
    clk_edge(1'b0);
    cmd_valid = 1'b0; cmd_op = 4'($urandom); cmd_opnd = 8'($urandom); bus_ready = 1'b0;
    #1;
    check("op_issue", op, cop);
    check("opnd_issue", opnd, copnd);
    check("rv_issue", result_valid, 8'h00);
    clk_edge(1'b0);
    for (int k = 0; k <= xk; k++) begin
      bus_ready = rdy_a[k]; bus_valid = vld_a[k]; bus_data = dat_a[k];
      bus_status = st_a[k]; alarm_clr = clr_a[k];
      #1;
      check("op_wait", op, 8'h08);
      check("opnd_wait", opnd, copnd);
      check("rv_wait", result_valid, 8'h00);
      check("cmd_ready_wait", cmd_ready, 8'h00);
      clk_edge(k == xk && cop == 4'h0);
    end
    bus_ready = 1'b1; bus_valid = 1'b0; bus_status = 2'b00; alarm_clr = 1'b0;
    #1;
    check("rv_done", result_valid, 8'h01);
    check("data_done", result_data, xdata);
    check("err_done", result_err, xerr);
    check("status_done", result_status, xst);
    check("cmd_ready_done", cmd_ready, 8'h00);
    h_data = xdata; h_err = xerr; h_status = xst; last_opnd = copnd;
    clk_edge(1'b0);
    check("rv_after", result_valid, 8'h00);
    check("data_after", result_data, h_data);
  endtask

  logic [3:0] rop;
  logic [7:0] ropnd, rd;
  logic       re;
  logic [1:0] rs;
  int         rk;

  initial begin
    reset = 1'b1; cmd_valid = 1'b1; cmd_op = 4'h2; cmd_opnd = 8'hFF;
    bus_ready = 1'b1; bus_valid = 1'b1; bus_data = 8'hAA; bus_status = 2'b01; alarm_clr = 1'b0;
    #2;
    reset_vals();
    clk_edge(1'b0);
    reset_vals();
    reset = 1'b0; cmd_valid = 1'b0; bus_valid = 1'b0; bus_status = 2'b00;

    // {op, opnd, ready_from, valid_at, data, latency, exp data, exp err}
    tbl[0] = '{4'h2, 8'h50, 0,  -1, 8'h00, 3,  8'h00, 1'b0};
    tbl[1] = '{4'h4, 8'h00, 0,  2,  8'h3C, 5,  8'h3C, 1'b0};
    tbl[2] = '{4'h7, 8'h11, 0,  -1, 8'h00, 18, 8'h00, 1'b1};
    tbl[3] = '{4'hA, 8'h22, 99, -1, 8'h00, 3,  8'h00, 1'b0};
    tbl[4] = '{4'h1, 8'h33, 5,  -1, 8'h00, 8,  8'h00, 1'b0};
    tbl[5] = '{4'h3, 8'h44, 99, -1, 8'h00, 18, 8'h00, 1'b1};
    tbl[6] = '{4'h6, 8'h55, 0,  15, 8'h77, 18, 8'h77, 1'b0};
    tbl[7] = '{4'h5, 8'h66, 99, 0,  8'hA5, 3,  8'hA5, 1'b0};
    tbl[8] = '{4'h0, 8'h77, 15, -1, 8'h00, 18, 8'h00, 1'b0};
    tbl[9] = '{4'hF, 8'h88, 99, 99, 8'h00, 3,  8'h00, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < TO; k++) begin
        rdy_a[k] = (k >= tbl[i].rdy_at);
        vld_a[k] = (k == tbl[i].vld_at);
        dat_a[k] = (k == tbl[i].vld_at) ? tbl[i].dat : 8'hEE;
        st_a[k]  = 2'b00;
        clr_a[k] = 1'b0;
      end
      run_cmd(tbl[i].cop, tbl[i].copnd, tbl[i].lat - 3, tbl[i].x_data, tbl[i].x_err, 2'b00);
    end

    // command offered while the bus is busy is ignored
    cmd_valid = 1'b1; cmd_op = 4'h6; cmd_opnd = 8'hC3; bus_ready = 1'b0;
    #1;
    check("busy_cmd_ready", cmd_ready, 8'h00);
    clk_edge(1'b0);
    check("busy_op", op, 8'h08);
    check("busy_opnd", opnd, last_opnd);
    clk_edge(1'b0);
    check("busy_op2", op, 8'h08);
    check("busy_rv", result_valid, 8'h00);
    for (int k = 0; k < TO; k++) begin
      rdy_a[k] = 1'b0; vld_a[k] = (k == 1); dat_a[k] = 8'h5A; st_a[k] = 2'b00; clr_a[k] = 1'b0;
    end
    run_cmd(4'h6, 8'hC3, 1, 8'h5A, 1'b0, 2'b00);

    // sticky alarms: set beats a simultaneous clear
    bus_status = 2'b01;
    clk_edge(1'b0);
    bus_status = 2'b00;
    clk_edge(1'b0);
    check("alarm_high_sticky", alarm_high, 8'h01);
    bus_status = 2'b10; alarm_clr = 1'b1;
    clk_edge(1'b0);
    check("alarm_high_cleared", alarm_high, 8'h00);
    check("alarm_low_set_wins", alarm_low, 8'h01);
    bus_status = 2'b00; alarm_clr = 1'b0;

    // RESET command clears the alarms on completion
    for (int k = 0; k < TO; k++) begin
      rdy_a[k] = 1'b1; vld_a[k] = 1'b0; dat_a[k] = 8'h00; st_a[k] = 2'b00; clr_a[k] = 1'b0;
    end
    run_cmd(4'h0, 8'h01, 0, 8'h00, 1'b0, 2'b00);
    check("reset_cmd_alarm_low", alarm_low, 8'h00);

    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < TO; k++) begin
        rdy_a[k] = ($urandom_range(0, 5) == 0);
        vld_a[k] = ($urandom_range(0, 5) == 0);
        dat_a[k] = 8'($urandom);
        st_a[k]  = 2'($urandom);
        clr_a[k] = ($urandom_range(0, 7) == 0);
      end
      rop = 4'($urandom);
      ropnd = 8'($urandom);
      model(rop, rk, rd, re, rs);
      run_cmd(rop, ropnd, rk, rd, re, rs);
    end

    // reset in the middle of an OUT_MIN wait
    cmd_op = 4'h5; cmd_opnd = 8'h9A; cmd_valid = 1'b1; bus_ready = 1'b1;
    bus_valid = 1'b0; bus_status = 2'b00; alarm_clr = 1'b0;
    #1;
    clk_edge(1'b0);
    cmd_valid = 1'b0; bus_ready = 1'b0;
    clk_edge(1'b0);
    bus_status = 2'b01;
    clk_edge(1'b0);
    bus_status = 2'b00; bus_ready = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    reset_vals();
    clk_edge(1'b0);
    check("rst_hold_rv", result_valid, 8'h00);
    reset = 1'b0;
    h_data = 8'h00; h_err = 1'b0; h_status = 2'b00; last_opnd = 8'h00;
    for (int k = 0; k < TO; k++) begin
      rdy_a[k] = 1'b0; vld_a[k] = 1'b0; dat_a[k] = 8'h00; st_a[k] = 2'b00; clr_a[k] = 1'b0;
    end
    run_cmd(4'h8, 8'h0F, 0, 8'h00, 1'b0, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
